// File: rtl/video_mode_sequencer_pkg.sv
// Shared definitions for the video mode sequencer.
//   - Mode encodings for the four supported resolutions.
//   - Sequencer state encoding.
//   - Per-mode timing record and a constant lookup function for it.
package video_mode_sequencer_pkg;

   localparam logic [1:0] MODE_640X480  = 2'd0;
   localparam logic [1:0] MODE_800X600  = 2'd1;
   localparam logic [1:0] MODE_1280X720 = 2'd2;
   localparam logic [1:0] MODE_1024X768 = 2'd3;

   localparam logic POL_NEG = 1'b0;
   localparam logic POL_POS = 1'b1;

   typedef enum logic [2:0] {
      ST_RUN       = 3'd0,
      ST_WAIT_EOF  = 3'd1,
      ST_DRAIN     = 3'd2,
      ST_RECONF    = 3'd3,
      ST_WAIT_LOCK = 3'd4,
      ST_SETTLE    = 3'd5,
      ST_ERROR     = 3'd6
   } state_e;

   typedef struct packed {
      logic [11:0] h_res;
      logic [11:0] v_res;
      logic [7:0]  h_fp;
      logic [7:0]  h_sync;
      logic [7:0]  h_bp;
      logic [5:0]  v_fp;
      logic [5:0]  v_sync;
      logic [5:0]  v_bp;
      logic        h_pol;
      logic        v_pol;
   } mode_timing_t;

   function automatic mode_timing_t mode_timing(input logic [1:0] mode);
      mode_timing_t t;
      case (mode)
         MODE_800X600:  t = '{h_res: 12'd800,  v_res: 12'd600,
                             h_fp: 8'd40,  h_sync: 8'd128, h_bp: 8'd88,
                             v_fp: 6'd1,   v_sync: 6'd4,   v_bp: 6'd23,
                             h_pol: POL_POS, v_pol: POL_POS};
         MODE_1280X720: t = '{h_res: 12'd1280, v_res: 12'd720,
                             h_fp: 8'd110, h_sync: 8'd40,  h_bp: 8'd220,
                             v_fp: 6'd5,   v_sync: 6'd5,   v_bp: 6'd20,
                             h_pol: POL_POS, v_pol: POL_POS};
         MODE_1024X768: t = '{h_res: 12'd1024, v_res: 12'd768,
                             h_fp: 8'd24,  h_sync: 8'd136, h_bp: 8'd160,
                             v_fp: 6'd3,   v_sync: 6'd6,   v_bp: 6'd29,
                             h_pol: POL_NEG, v_pol: POL_NEG};
         default:       t = '{h_res: 12'd640,  v_res: 12'd480,
                             h_fp: 8'd16,  h_sync: 8'd96,  h_bp: 8'd48,
                             v_fp: 6'd10,  v_sync: 6'd2,   v_bp: 6'd33,
                             h_pol: POL_NEG, v_pol: POL_NEG};
      endcase
      return t;
   endfunction

endpackage

// File: rtl/video_mode_sequencer_frame_tick_sync.sv
// Brings the pixel-domain frame toggle and the asynchronous MMCM lock into
// the CLK domain.
//   CLK          : system clock
//   i_rst        : synchronous active-high reset
//   i_frame_tgl  : toggles once per frame (pix_clk domain)
//   i_clk_lock   : MMCM lock (asynchronous)
//   o_frame_tick : one-CLK pulse per frame-toggle edge
//   o_lock       : synchronised lock level
module video_mode_sequencer_frame_tick_sync (
   input  logic CLK,
   input  logic i_rst,
   input  logic i_frame_tgl,
   input  logic i_clk_lock,
   output logic o_frame_tick,
   output logic o_lock
);

   // [1:0] is the 2-FF synchroniser, [2] holds the previous synced value
   // for edge detection.
   logic [2:0] tgl_q, tgl_d;
   logic [1:0] lock_q, lock_d;

   always_comb begin
      tgl_d  = {tgl_q[1:0], i_frame_tgl};
      lock_d = {lock_q[0], i_clk_lock};
   end

   always_ff @(posedge CLK) begin
      if (i_rst) begin
         tgl_q  <= '0;
         lock_q <= '0;
      end else begin
         tgl_q  <= tgl_d;
         lock_q <= lock_d;
      end
   end

   // Either toggle direction marks a frame boundary.
   assign o_frame_tick = tgl_q[1] ^ tgl_q[2];
   assign o_lock       = lock_q[1];

endmodule

// File: rtl/video_mode_sequencer.sv
// Control-plane sequencer for the test pattern generator and its pixel
// clock manager. Pattern/monitor changes are applied at a frame boundary;
// resolution changes run blank -> drain -> reconfigure -> lock -> settle.
//   CLK, i_rst                 : system clock, synchronous active-high reset
//   i_mode_sel/img_sel/out_sel : debounced switch requests
//   i_frame_tgl                : per-frame toggle from the pixel domain
//   i_clk_lock                 : pixel MMCM lock (asynchronous)
//   i_reconf_done              : clock manager acknowledge
//   o_reconf_req/o_reconf_mode : clock reconfiguration request and mode
//   o_h_* / o_v_*              : timing parameters to the generator
//   o_img_select/o_out_select  : pattern and monitor select
//   o_blank, o_tg_rst          : output blanking and generator reset
//   o_busy, o_error            : status (not RUN / ERROR)
module video_mode_sequencer
   import video_mode_sequencer_pkg::*;
#(
   parameter int unsigned SETTLE_FRAMES = 2,
   parameter int unsigned FRAME_TIMEOUT = 2000000,
   parameter int unsigned LOCK_TIMEOUT  = 1048576
) (
   input  logic        CLK,
   input  logic        i_rst,
   input  logic [1:0]  i_mode_sel,
   input  logic [1:0]  i_img_sel,
   input  logic        i_out_sel,
   input  logic        i_frame_tgl,
   input  logic        i_clk_lock,
   input  logic        i_reconf_done,
   output logic        o_reconf_req,
   output logic [1:0]  o_reconf_mode,
   output logic [11:0] o_h_res,
   output logic [11:0] o_v_res,
   output logic [7:0]  o_h_fp,
   output logic [7:0]  o_h_sync,
   output logic [7:0]  o_h_bp,
   output logic [5:0]  o_v_fp,
   output logic [5:0]  o_v_sync,
   output logic [5:0]  o_v_bp,
   output logic        o_h_pol,
   output logic        o_v_pol,
   output logic [1:0]  o_img_select,
   output logic        o_out_select,
   output logic        o_blank,
   output logic        o_tg_rst,
   output logic        o_busy,
   output logic        o_error
);

   localparam int FT_W  = (FRAME_TIMEOUT > 1) ? $clog2(FRAME_TIMEOUT) : 1;
   localparam int LT_W  = (LOCK_TIMEOUT > 1)  ? $clog2(LOCK_TIMEOUT)  : 1;
   localparam int SET_W = $clog2(SETTLE_FRAMES + 1);

   // Timers expire after exactly *_TIMEOUT cycles counted from their clear.
   localparam logic [FT_W-1:0]  FT_LAST     = FT_W'(FRAME_TIMEOUT - 1);
   localparam logic [LT_W-1:0]  LT_LAST     = LT_W'(LOCK_TIMEOUT - 1);
   localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_FRAMES - 1);

   logic frame_tick;
   logic lock_s;

   video_mode_sequencer_frame_tick_sync u_sync (
      .CLK          (CLK),
      .i_rst        (i_rst),
      .i_frame_tgl  (i_frame_tgl),
      .i_clk_lock   (i_clk_lock),
      .o_frame_tick (frame_tick),
      .o_lock       (lock_s)
   );

   state_e         state_q, state_d;
   logic [1:0]     target_q, target_d;
   logic [1:0]     cur_mode_q, cur_mode_d;
   logic           mode_pend_q, mode_pend_d;
   logic           retry_q, retry_d;
   logic [SET_W-1:0] settle_cnt_q, settle_cnt_d;
   logic [FT_W-1:0]  ftimer_q, ftimer_d;
   logic [LT_W-1:0]  ltimer_q, ltimer_d;
   mode_timing_t   timing_q, timing_d;
   logic [1:0]     reconf_mode_q, reconf_mode_d;
   logic [1:0]     img_q, img_d;
   logic           out_q, out_d;
   logic           blank_q, blank_d;
   logic           tg_rst_q, tg_rst_d;
   logic           req_q, req_d;
   logic           lock_low_q, lock_low_d;

   logic f_exp, l_exp, frame_evt, lock_lost;

   always_comb begin
      f_exp      = (ftimer_q == FT_LAST);
      l_exp      = (ltimer_q == LT_LAST);
      // A frame timeout stands in for a missing tick.
      frame_evt  = frame_tick | f_exp;
      // Lock must read low on two consecutive cycles to count as lost.
      lock_low_d = ~lock_s;
      lock_lost  = ~lock_s & lock_low_q;
   end

   always_comb begin
      state_d       = state_q;
      target_d      = target_q;
      cur_mode_d    = cur_mode_q;
      mode_pend_d   = mode_pend_q;
      retry_d       = retry_q;
      settle_cnt_d  = settle_cnt_q;
      timing_d      = timing_q;
      reconf_mode_d = reconf_mode_q;
      img_d         = img_q;
      out_d         = out_q;
      blank_d       = blank_q;
      tg_rst_d      = tg_rst_q;
      req_d         = req_q;
      // Saturating timers; each state clears the one it uses on entry.
      ftimer_d      = f_exp ? ftimer_q : ftimer_q + FT_W'(1);
      ltimer_d      = l_exp ? ltimer_q : ltimer_q + LT_W'(1);

      case (state_q)
         ST_RUN: begin
            ftimer_d = '0;
            if (lock_lost) begin
               blank_d  = 1'b1;
               tg_rst_d = 1'b1;
               ltimer_d = '0;
               retry_d  = 1'b0;
               state_d  = ST_WAIT_LOCK;
            end else if (i_mode_sel != cur_mode_q) begin
               target_d    = i_mode_sel;
               mode_pend_d = 1'b1;
               state_d     = ST_WAIT_EOF;
            end else if ((i_img_sel != img_q) || (i_out_sel != out_q)) begin
               mode_pend_d = 1'b0;
               state_d     = ST_WAIT_EOF;
            end
         end

         ST_WAIT_EOF: begin
            if (frame_evt) begin
               ftimer_d = '0;
               if (mode_pend_q) begin
                  blank_d = 1'b1;
                  state_d = ST_DRAIN;
               end else begin
                  // Current inputs, not the ones that triggered the wait.
                  img_d   = i_img_sel;
                  out_d   = i_out_sel;
                  state_d = ST_RUN;
               end
            end
         end

         ST_DRAIN: begin
            if (frame_evt) begin
               tg_rst_d      = 1'b1;
               // Hold the request back until a stale acknowledge clears.
               req_d         = ~i_reconf_done;
               timing_d      = mode_timing(target_q);
               reconf_mode_d = target_q;
               retry_d       = 1'b0;
               state_d       = ST_RECONF;
            end
         end

         ST_RECONF: begin
            if (req_q) begin
               if (i_reconf_done) begin
                  req_d    = 1'b0;
                  ltimer_d = '0;
                  state_d  = ST_WAIT_LOCK;
               end
            end else if (!i_reconf_done) begin
               req_d = 1'b1;
            end
         end

         ST_WAIT_LOCK: begin
            if (lock_s) begin
               tg_rst_d     = 1'b0;
               cur_mode_d   = target_q;
               settle_cnt_d = '0;
               ftimer_d     = '0;
               state_d      = ST_SETTLE;
            end else if (l_exp) begin
               if (!retry_q) begin
                  retry_d = 1'b1;
                  state_d = ST_RECONF;
               end else begin
                  state_d = ST_ERROR;
               end
            end
         end

         ST_SETTLE: begin
            if (frame_evt) begin
               ftimer_d = '0;
               if (settle_cnt_q >= SETTLE_LAST) begin
                  img_d   = i_img_sel;
                  out_d   = i_out_sel;
                  blank_d = 1'b0;
                  state_d = ST_RUN;
               end else begin
                  settle_cnt_d = settle_cnt_q + SET_W'(1);
               end
            end
         end

         ST_ERROR: begin
            blank_d  = 1'b1;
            tg_rst_d = 1'b1;
            if (i_mode_sel != target_q) begin
               target_d      = i_mode_sel;
               retry_d       = 1'b0;
               timing_d      = mode_timing(i_mode_sel);
               reconf_mode_d = i_mode_sel;
               req_d         = 1'b0;
               state_d       = ST_RECONF;
            end
         end

         default: begin
            state_d = ST_ERROR;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (i_rst) begin
         // Reset lands in RECONF for mode 0 so power-up runs a full sequence.
         state_q       <= ST_RECONF;
         target_q      <= MODE_640X480;
         cur_mode_q    <= MODE_640X480;
         mode_pend_q   <= 1'b0;
         retry_q       <= 1'b0;
         settle_cnt_q  <= '0;
         ftimer_q      <= '0;
         ltimer_q      <= '0;
         timing_q      <= mode_timing(MODE_640X480);
         reconf_mode_q <= MODE_640X480;
         img_q         <= 2'd0;
         out_q         <= 1'b0;
         blank_q       <= 1'b1;
         tg_rst_q      <= 1'b1;
         req_q         <= 1'b0;
         lock_low_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         target_q      <= target_d;
         cur_mode_q    <= cur_mode_d;
         mode_pend_q   <= mode_pend_d;
         retry_q       <= retry_d;
         settle_cnt_q  <= settle_cnt_d;
         ftimer_q      <= ftimer_d;
         ltimer_q      <= ltimer_d;
         timing_q      <= timing_d;
         reconf_mode_q <= reconf_mode_d;
         img_q         <= img_d;
         out_q         <= out_d;
         blank_q       <= blank_d;
         tg_rst_q      <= tg_rst_d;
         req_q         <= req_d;
         lock_low_q    <= lock_low_d;
      end
   end

   assign o_reconf_req  = req_q;
   assign o_reconf_mode = reconf_mode_q;
   assign o_h_res       = timing_q.h_res;
   assign o_v_res       = timing_q.v_res;
   assign o_h_fp        = timing_q.h_fp;
   assign o_h_sync      = timing_q.h_sync;
   assign o_h_bp        = timing_q.h_bp;
   assign o_v_fp        = timing_q.v_fp;
   assign o_v_sync      = timing_q.v_sync;
   assign o_v_bp        = timing_q.v_bp;
   assign o_h_pol       = timing_q.h_pol;
   assign o_v_pol       = timing_q.v_pol;
   assign o_img_select  = img_q;
   assign o_out_select  = out_q;
   assign o_blank       = blank_q;
   assign o_tg_rst      = tg_rst_q;
   assign o_busy        = (state_q != ST_RUN);
   assign o_error       = (state_q == ST_ERROR);

endmodule

// File: tb/tb_video_mode_sequencer.sv
module tb_video_mode_sequencer;

   localparam int FT = 200;
   localparam int LT = 300;

   logic        CLK = 1'b0;
   logic        i_rst = 1'b1;
   logic [1:0]  i_mode_sel = 2'd0;
   logic [1:0]  i_img_sel = 2'd1;
   logic        i_out_sel = 1'b0;
   logic        i_frame_tgl = 1'b0;
   logic        i_clk_lock = 1'b0;
   logic        i_reconf_done = 1'b0;
   logic        o_reconf_req;
   logic [1:0]  o_reconf_mode;
   logic [11:0] o_h_res, o_v_res;
   logic [7:0]  o_h_fp, o_h_sync, o_h_bp;
   logic [5:0]  o_v_fp, o_v_sync, o_v_bp;
   logic        o_h_pol, o_v_pol;
   logic [1:0]  o_img_select;
   logic        o_out_select, o_blank, o_tg_rst, o_busy, o_error;

   int n_tests = 0;
   int n_fail  = 0;

   video_mode_sequencer #(
      .SETTLE_FRAMES (2),
      .FRAME_TIMEOUT (FT),
      .LOCK_TIMEOUT  (LT)
   ) dut (
      .CLK           (CLK),
      .i_rst         (i_rst),
      .i_mode_sel    (i_mode_sel),
      .i_img_sel     (i_img_sel),
      .i_out_sel     (i_out_sel),
      .i_frame_tgl   (i_frame_tgl),
      .i_clk_lock    (i_clk_lock),
      .i_reconf_done (i_reconf_done),
      .o_reconf_req  (o_reconf_req),
      .o_reconf_mode (o_reconf_mode),
      .o_h_res       (o_h_res),
      .o_v_res       (o_v_res),
      .o_h_fp        (o_h_fp),
      .o_h_sync      (o_h_sync),
      .o_h_bp        (o_h_bp),
      .o_v_fp        (o_v_fp),
      .o_v_sync      (o_v_sync),
      .o_v_bp        (o_v_bp),
      .o_h_pol       (o_h_pol),
      .o_v_pol       (o_v_pol),
      .o_img_select  (o_img_select),
      .o_out_select  (o_out_select),
      .o_blank       (o_blank),
      .o_tg_rst      (o_tg_rst),
      .o_busy        (o_busy),
      .o_error       (o_error)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [1:0] mode;
      logic [1:0] img;
      logic       outs;
      int h_res, v_res, h_fp, h_sync, h_bp, v_fp, v_sync, v_bp, h_pol, v_pol;
   } vec_t;

   vec_t vecs[4];

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_until(input string name, input int sel, input int max);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < max && !hit; i++) begin
         cycles(1);
         case (sel)
            0:       hit = (o_reconf_req == 1'b1);
            1:       hit = (o_tg_rst == 1'b0);
            default: hit = (o_busy == 1'b0);
         endcase
      end
      n_tests++;
      if (!hit) begin
         n_fail++;
         $display("FAIL wait %s: not reached within %0d cycles, required reached", name, max);
      end
   endtask

   task automatic toggle_frame();
      i_frame_tgl = ~i_frame_tgl;
   endtask

   // Full mode-change sequence from RUN back to RUN with a cooperative
   // clock manager that drops lock during reconfiguration.
   task automatic run_seq(input logic [1:0] m, input logic [1:0] img, input logic o);
      i_mode_sel = m;
      i_img_sel  = img;
      i_out_sel  = o;
      cycles(3);
      toggle_frame();
      cycles(4);
      toggle_frame();
      wait_until("seq req", 0, 10);
      i_clk_lock = 1'b0;
      cycles(5);
      i_reconf_done = 1'b1;
      cycles(1);
      i_reconf_done = 1'b0;
      cycles(10);
      i_clk_lock = 1'b1;
      wait_until("seq tg_rst low", 1, 10);
      toggle_frame();
      cycles(5);
      toggle_frame();
      wait_until("seq run", 2, 10);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{2'd1, 2'd3, 1'b1,  800, 600,  40, 128,  88,  1, 4, 23, 1, 1};
      vecs[1] = '{2'd3, 2'd0, 1'b1, 1024, 768,  24, 136, 160,  3, 6, 29, 0, 0};
      vecs[2] = '{2'd0, 2'd2, 1'b0,  640, 480,  16,  96,  48, 10, 2, 33, 0, 0};
      vecs[3] = '{2'd2, 2'd1, 1'b0, 1280, 720, 110,  40, 220,  5, 5, 20, 1, 1};

      // ---- reset values and power-up sequence
      cycles(3);
      chk("rst blank", int'(o_blank), 1);
      chk("rst tg_rst", int'(o_tg_rst), 1);
      chk("rst busy", int'(o_busy), 1);
      chk("rst req", int'(o_reconf_req), 0);
      chk("rst error", int'(o_error), 0);
      chk("rst h_res", int'(o_h_res), 640);
      chk("rst v_bp", int'(o_v_bp), 33);
      chk("rst img", int'(o_img_select), 0);
      chk("rst out", int'(o_out_select), 0);
      i_rst = 1'b0;
      chk("pwr req before", int'(o_reconf_req), 0);
      cycles(1);
      chk("pwr req raised", int'(o_reconf_req), 1);
      chk("pwr reconf_mode", int'(o_reconf_mode), 0);
      cycles(4);
      i_reconf_done = 1'b1;
      cycles(1);
      i_reconf_done = 1'b0;
      chk("pwr req dropped", int'(o_reconf_req), 0);
      cycles(100);
      i_clk_lock = 1'b1;
      cycles(2);
      chk("pwr tg_rst held", int'(o_tg_rst), 1);
      cycles(1);
      chk("pwr tg_rst released", int'(o_tg_rst), 0);
      toggle_frame();
      cycles(3);
      chk("pwr blank after tick1", int'(o_blank), 1);
      cycles(2);
      toggle_frame();
      cycles(2);
      chk("pwr blank before tick2", int'(o_blank), 1);
      cycles(1);
      chk("pwr blank after tick2", int'(o_blank), 0);
      chk("pwr busy", int'(o_busy), 0);
      chk("pwr h_res", int'(o_h_res), 640);
      chk("pwr img", int'(o_img_select), 1);

      // ---- pattern change waits for the frame boundary
      i_img_sel = 2'd2;
      cycles(3);
      chk("img held", int'(o_img_select), 1);
      chk("img busy", int'(o_busy), 1);
      toggle_frame();
      cycles(2);
      chk("img held tick-1", int'(o_img_select), 1);
      cycles(1);
      chk("img applied", int'(o_img_select), 2);
      chk("img no blank", int'(o_blank), 0);
      chk("img run", int'(o_busy), 0);

      // ---- mode 0 -> 2, cycle-exact
      i_mode_sel = 2'd2;
      cycles(1);
      chk("m2 blank before tick", int'(o_blank), 0);
      cycles(2);
      toggle_frame();
      cycles(3);
      chk("m2 blank tick1", int'(o_blank), 1);
      chk("m2 no req tick1", int'(o_reconf_req), 0);
      chk("m2 tg_rst tick1", int'(o_tg_rst), 0);
      cycles(2);
      toggle_frame();
      cycles(2);
      chk("m2 no req yet", int'(o_reconf_req), 0);
      chk("m2 h_res old", int'(o_h_res), 640);
      cycles(1);
      chk("m2 req tick2", int'(o_reconf_req), 1);
      chk("m2 tg_rst tick2", int'(o_tg_rst), 1);
      chk("m2 h_res", int'(o_h_res), 1280);
      chk("m2 h_bp", int'(o_h_bp), 220);
      chk("m2 h_pol", int'(o_h_pol), 1);
      chk("m2 v_pol", int'(o_v_pol), 1);
      chk("m2 reconf_mode", int'(o_reconf_mode), 2);
      i_clk_lock = 1'b0;
      cycles(5);
      i_reconf_done = 1'b1;
      cycles(1);
      i_reconf_done = 1'b0;
      chk("m2 req dropped", int'(o_reconf_req), 0);
      cycles(20);
      i_clk_lock = 1'b1;
      cycles(3);
      chk("m2 tg_rst released", int'(o_tg_rst), 0);
      toggle_frame();
      cycles(5);
      toggle_frame();
      cycles(3);
      chk("m2 run", int'(o_busy), 0);
      chk("m2 unblank", int'(o_blank), 0);
      chk("m2 img kept", int'(o_img_select), 2);

      // ---- table of mode sequences
      for (int v = 0; v < 4; v++) begin
         run_seq(vecs[v].mode, vecs[v].img, vecs[v].outs);
         chk($sformatf("vec%0d h_res", v), int'(o_h_res), vecs[v].h_res);
         chk($sformatf("vec%0d v_res", v), int'(o_v_res), vecs[v].v_res);
         chk($sformatf("vec%0d h_fp", v), int'(o_h_fp), vecs[v].h_fp);
         chk($sformatf("vec%0d h_sync", v), int'(o_h_sync), vecs[v].h_sync);
         chk($sformatf("vec%0d h_bp", v), int'(o_h_bp), vecs[v].h_bp);
         chk($sformatf("vec%0d v_fp", v), int'(o_v_fp), vecs[v].v_fp);
         chk($sformatf("vec%0d v_sync", v), int'(o_v_sync), vecs[v].v_sync);
         chk($sformatf("vec%0d v_bp", v), int'(o_v_bp), vecs[v].v_bp);
         chk($sformatf("vec%0d h_pol", v), int'(o_h_pol), vecs[v].h_pol);
         chk($sformatf("vec%0d v_pol", v), int'(o_v_pol), vecs[v].v_pol);
         chk($sformatf("vec%0d reconf_mode", v), int'(o_reconf_mode), int'(vecs[v].mode));
         chk($sformatf("vec%0d img", v), int'(o_img_select), int'(vecs[v].img));
         chk($sformatf("vec%0d out", v), int'(o_out_select), int'(vecs[v].outs));
         chk($sformatf("vec%0d blank", v), int'(o_blank), 0);
         chk($sformatf("vec%0d tg_rst", v), int'(o_tg_rst), 0);
      end

      // ---- no frame toggles: change applied on the frame timeout
      i_img_sel = 2'd3;
      cycles(FT);
      chk("fto img held", int'(o_img_select), 1);
      cycles(1);
      chk("fto img applied", int'(o_img_select), 3);
      chk("fto no blank", int'(o_blank), 0);

      // ---- lock never returns: one retry, then ERROR, then restart
      i_mode_sel = 2'd1;
      cycles(3);
      toggle_frame();
      cycles(4);
      toggle_frame();
      cycles(3);
      chk("lto req", int'(o_reconf_req), 1);
      i_clk_lock = 1'b0;
      cycles(5);
      i_reconf_done = 1'b1;
      cycles(1);
      i_reconf_done = 1'b0;
      cycles(LT);
      chk("lto no retry yet", int'(o_reconf_req), 0);
      chk("lto no error yet", int'(o_error), 0);
      cycles(1);
      chk("lto retry req", int'(o_reconf_req), 1);
      cycles(2);
      i_reconf_done = 1'b1;
      cycles(1);
      i_reconf_done = 1'b0;
      cycles(LT - 1);
      chk("lto error pending", int'(o_error), 0);
      cycles(1);
      chk("lto error", int'(o_error), 1);
      chk("lto err blank", int'(o_blank), 1);
      chk("lto err tg_rst", int'(o_tg_rst), 1);
      chk("lto err req", int'(o_reconf_req), 0);
      cycles(5);
      chk("lto error stays", int'(o_error), 1);
      i_mode_sel = 2'd3;
      cycles(1);
      chk("lto restart error clr", int'(o_error), 0);
      chk("lto restart mode", int'(o_reconf_mode), 3);
      chk("lto restart h_res", int'(o_h_res), 1024);
      cycles(1);
      chk("lto restart req", int'(o_reconf_req), 1);
      cycles(3);
      i_reconf_done = 1'b1;
      cycles(1);
      i_reconf_done = 1'b0;
      cycles(5);
      i_clk_lock = 1'b1;
      wait_until("lto tg_rst low", 1, 10);
      toggle_frame();
      cycles(5);
      toggle_frame();
      wait_until("lto run", 2, 10);

      // ---- lock loss in RUN
      i_clk_lock = 1'b0;
      cycles(3);
      chk("loss blank not yet", int'(o_blank), 0);
      cycles(1);
      chk("loss blank", int'(o_blank), 1);
      chk("loss tg_rst", int'(o_tg_rst), 1);
      chk("loss busy", int'(o_busy), 1);
      cycles(6);
      i_clk_lock = 1'b1;
      cycles(2);
      chk("loss tg_rst held", int'(o_tg_rst), 1);
      cycles(1);
      chk("loss tg_rst released", int'(o_tg_rst), 0);
      toggle_frame();
      cycles(5);
      toggle_frame();
      cycles(3);
      chk("loss recovered busy", int'(o_busy), 0);
      chk("loss recovered blank", int'(o_blank), 0);
      chk("loss mode kept", int'(o_h_res), 1024);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
